// File: rtl/vibrato_delay_line.sv
// -----------------------------------------------------------------------------
// vibrato_delay_line
//
// Pitch-vibrato delay stage. A triangle LFO (0..255..0, 510 ticks per period)
// sweeps the read delay of a circular sample buffer. The LFO advances one step
// every max(frequency,1) clock cycles. When disabled, the LFO is parked at 0
// and samples are passed straight through, with the same 2-cycle latency.
//
// Ports
//   CLK              system clock
//   RST              asynchronous reset, active-high
//   frequency        clock cycles per LFO step (0 behaves as 1)
//   disabled         1 = bypass, 0 = vibrato active
//   sample_in        input sample (two's complement)
//   sample_in_valid  single-cycle strobe qualifying sample_in
//   sample_out       output sample, held between strobes
//   sample_out_valid single-cycle strobe, 2 cycles after sample_in_valid
//   lfo_value        current triangle value
// -----------------------------------------------------------------------------
module vibrato_delay_line #(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 10,
    parameter int BASE_DELAY  = 16,
    parameter int DEPTH_SHIFT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       frequency,
    input  logic              disabled,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_in_valid,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_out_valid,
    output logic [7:0]        lfo_value
);

    localparam int DEPTH = 1 << ADDR_W;

    // ---------------- LFO ----------------
    logic [31:0] step_cnt_q, step_cnt_d;
    logic [7:0]  tri_val_q, tri_val_d;
    logic        dir_down_q, dir_down_d;
    logic [31:0] period_m1;
    logic        tick;

    // Compare with >= so that lowering frequency mid-count ticks immediately
    // instead of waiting for a 32-bit wrap.
    assign period_m1 = (frequency == 32'd0) ? 32'd0 : frequency - 32'd1;
    assign tick      = (step_cnt_q >= period_m1);

    always_comb begin
        step_cnt_d = step_cnt_q + 32'd1;
        tri_val_d  = tri_val_q;
        dir_down_d = dir_down_q;
        if (disabled) begin
            step_cnt_d = 32'd0;
            tri_val_d  = 8'd0;
            dir_down_d = 1'b0;
        end else if (tick) begin
            step_cnt_d = 32'd0;
            if (!dir_down_q) begin
                tri_val_d = tri_val_q + 8'd1;
                if (tri_val_q == 8'd254) dir_down_d = 1'b1;
            end else begin
                tri_val_d = tri_val_q - 8'd1;
                if (tri_val_q == 8'd1) dir_down_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            step_cnt_q <= 32'd0;
            tri_val_q  <= 8'd0;
            dir_down_q <= 1'b0;
        end else begin
            step_cnt_q <= step_cnt_d;
            tri_val_q  <= tri_val_d;
            dir_down_q <= dir_down_d;
        end
    end

    assign lfo_value = tri_val_q;

    // ---------------- Delay pipeline ----------------
    logic [ADDR_W-1:0] delay;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_q, fill_d;

    assign delay = ADDR_W'(BASE_DELAY) + ADDR_W'(tri_val_q >> DEPTH_SHIFT);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (sample_in_valid) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = (fill_q == {ADDR_W{1'b1}}) ? fill_q : fill_q + 1'b1;
        end
    end

    // S0 -> S1 stage registers
    logic [ADDR_W-1:0] rd_addr_q;
    logic              s1_valid_q, s1_byp_q, s1_under_q;
    logic [DATA_W-1:0] s1_byp_data_q;
    // S1 -> S2 stage registers
    logic              s2_valid_q, s2_byp_q, s2_under_q;
    logic [DATA_W-1:0] s2_byp_data_q;
    logic [DATA_W-1:0] ram_rd_q;
    logic [DATA_W-1:0] out_hold_q;
    logic [DATA_W-1:0] out_sel;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q      <= '0;
            fill_q        <= '0;
            rd_addr_q     <= '0;
            s1_valid_q    <= 1'b0;
            s1_byp_q      <= 1'b0;
            s1_under_q    <= 1'b0;
            s1_byp_data_q <= '0;
            s2_valid_q    <= 1'b0;
            s2_byp_q      <= 1'b0;
            s2_under_q    <= 1'b0;
            s2_byp_data_q <= '0;
            out_hold_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            s1_valid_q <= sample_in_valid;
            if (sample_in_valid) begin
                rd_addr_q     <= wr_ptr_q - delay;
                s1_byp_q      <= disabled;
                s1_byp_data_q <= sample_in;
                s1_under_q    <= (fill_q < delay);
            end
            s2_valid_q    <= s1_valid_q;
            s2_byp_q      <= s1_byp_q;
            s2_under_q    <= s1_under_q;
            s2_byp_data_q <= s1_byp_data_q;
            if (s2_valid_q) out_hold_q <= out_sel;
        end
    end

    // Sample buffer: plain write port plus registered read so it maps onto
    // block RAM. Contents deliberately survive reset. Because delay >= 1 the
    // read address never matches the address written in the same cycle.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (sample_in_valid) mem[wr_ptr_q] <= sample_in;
        if (s1_valid_q) ram_rd_q <= mem[rd_addr_q];
    end

    always_comb begin
        out_sel = ram_rd_q;
        if (s2_byp_q)        out_sel = s2_byp_data_q;
        else if (s2_under_q) out_sel = '0;
    end

    // The RAM output register already provides the second pipeline stage, so
    // the strobe-cycle value is muxed in combinationally and captured into
    // out_hold_q to keep sample_out stable between strobes.
    assign sample_out       = s2_valid_q ? out_sel : out_hold_q;
    assign sample_out_valid = s2_valid_q;

endmodule

// File: tb/tb_vibrato_delay_line.sv
module tb_vibrato_delay_line;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] frequency = 32'd4;
    logic        disabled = 1'b1;
    logic [23:0] sample_in = '0;
    logic        sample_in_valid = 1'b0;
    logic [23:0] sample_out;
    logic        sample_out_valid;
    logic [7:0]  lfo_value;

    int n_tests = 0;
    int n_fail  = 0;

    vibrato_delay_line #(
        .DATA_W(24), .ADDR_W(10), .BASE_DELAY(16), .DEPTH_SHIFT(1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .frequency(frequency),
        .disabled(disabled),
        .sample_in(sample_in),
        .sample_in_valid(sample_in_valid),
        .sample_out(sample_out),
        .sample_out_valid(sample_out_valid),
        .lfo_value(lfo_value)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        sample_in_valid = 1'b0;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        step();
        n_tests++;
        if (sample_out !== 24'h0 || sample_out_valid !== 1'b0 || lfo_value !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_state: out=%h valid=%b lfo=%0d, required 0/0/0",
                     sample_out, sample_out_valid, lfo_value);
        end
        RST = 1'b0;
        disabled = 1'b1;
        sample_in = 24'hABCDEF; sample_in_valid = 1'b1;
        step();
        sample_in = 24'h123456;
        step();
        n_tests++;
        if (sample_out !== 24'hABCDEF || sample_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prestream: out=%h valid=%b, required abcdef/1",
                     sample_out, sample_out_valid);
        end
        sample_in = 24'h654321;
        #3 RST = 1'b1;
        #1;
        n_tests++;
        if (sample_out !== 24'h0 || sample_out_valid !== 1'b0 || lfo_value !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_async: out=%h valid=%b lfo=%0d, required 0/0/0",
                     sample_out, sample_out_valid, lfo_value);
        end
        sample_in_valid = 1'b0;
        step();
        RST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (sample_out_valid !== 1'b0 || sample_out !== 24'h0) begin
                n_fail++;
                $display("FAIL reset_no_strobe c%0d: valid=%b out=%h, required 0/0",
                         c, sample_out_valid, sample_out);
            end
        end
        disabled = 1'b0;
        sample_in = 24'h111111; sample_in_valid = 1'b1;
        step();
        sample_in_valid = 1'b0;
        step();
        n_tests++;
        if (sample_out_valid !== 1'b1 || sample_out !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_first_out: valid=%b out=%h, required 1/000000",
                     sample_out_valid, sample_out);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_bypass();
        disabled = 1'b1;
        sample_in = 24'h000123; sample_in_valid = 1'b1;
        step();
        sample_in = 24'h7FFFFF;
        step();
        sample_in_valid = 1'b0;
        n_tests++;
        if (sample_out_valid !== 1'b1 || sample_out !== 24'h000123 || lfo_value !== 8'h0) begin
            n_fail++;
            $display("FAIL bypass_first: valid=%b out=%h lfo=%0d, required 1/000123/0",
                     sample_out_valid, sample_out, lfo_value);
        end
        step();
        n_tests++;
        if (sample_out_valid !== 1'b1 || sample_out !== 24'h7FFFFF) begin
            n_fail++;
            $display("FAIL bypass_second: valid=%b out=%h, required 1/7fffff",
                     sample_out_valid, sample_out);
        end
        step();
        n_tests++;
        if (sample_out_valid !== 1'b0 || sample_out !== 24'h7FFFFF || lfo_value !== 8'h0) begin
            n_fail++;
            $display("FAIL bypass_hold: valid=%b out=%h lfo=%0d, required 0/7fffff/0",
                     sample_out_valid, sample_out, lfo_value);
        end
        $display("[TB] test_bypass done");
    endtask

    task automatic test_lfo_rate();
        int s;
        int exp_v;
        int bad;
        disabled = 1'b1;
        step();
        disabled = 1'b0;
        frequency = 32'd4;
        bad = 0;
        for (int c = 1; c <= 2044; c++) begin
            step();
            s = c / 4;
            if (s <= 255)      exp_v = s;
            else if (s <= 510) exp_v = 510 - s;
            else               exp_v = s - 510;
            n_tests++;
            if (lfo_value !== 8'(exp_v)) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL lfo_rate cycle %0d: lfo=%0d, required %0d", c, lfo_value, exp_v);
            end
        end
        $display("[TB] test_lfo_rate done");
    endtask

    task automatic test_freq_zero();
        disabled = 1'b1;
        frequency = 32'd0;
        step();
        disabled = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step();
            n_tests++;
            if (lfo_value !== 8'(c)) begin
                n_fail++;
                $display("FAIL freq_zero cycle %0d: lfo=%0d, required %0d", c, lfo_value, c);
            end
        end
        frequency = 32'd19531;
        for (int c = 0; c < 10; c++) step();
        n_tests++;
        if (lfo_value !== 8'd5) begin
            n_fail++;
            $display("FAIL freq_slow_hold: lfo=%0d, required 5", lfo_value);
        end
        frequency = 32'd3;
        step();
        n_tests++;
        if (lfo_value !== 8'd6) begin
            n_fail++;
            $display("FAIL freq_switch_tick: lfo=%0d, required 6", lfo_value);
        end
        step();
        step();
        n_tests++;
        if (lfo_value !== 8'd6) begin
            n_fail++;
            $display("FAIL freq_switch_wait: lfo=%0d, required 6", lfo_value);
        end
        step();
        n_tests++;
        if (lfo_value !== 8'd7) begin
            n_fail++;
            $display("FAIL freq_switch_next: lfo=%0d, required 7", lfo_value);
        end
        $display("[TB] test_freq_zero done");
    endtask

    task automatic test_fixed_delay();
        int k;
        logic [23:0] exp_v;
        pulse_reset();
        disabled = 1'b0;
        frequency = 32'hFFFFFFFF;
        for (int it = 0; it < 42; it++) begin
            step();
            if (it >= 2) begin
                k = it - 1;
                exp_v = (k <= 16) ? 24'h0 : 24'(k - 16);
                n_tests++;
                if (sample_out_valid !== 1'b1 || sample_out !== exp_v) begin
                    n_fail++;
                    $display("FAIL fixed_delay out %0d: valid=%b out=%h, required 1/%h",
                             k, sample_out_valid, sample_out, exp_v);
                end
            end
            if (it < 40) begin
                sample_in = 24'(it + 1);
                sample_in_valid = 1'b1;
            end else begin
                sample_in_valid = 1'b0;
            end
        end
        n_tests++;
        if (lfo_value !== 8'h0) begin
            n_fail++;
            $display("FAIL fixed_delay_lfo: lfo=%0d, required 0", lfo_value);
        end
        $display("[TB] test_fixed_delay done");
    endtask

    task automatic test_wrap();
        int k;
        int bad;
        bit reached;
        logic [23:0] exp_v;
        pulse_reset();
        disabled = 1'b0;
        frequency = 32'd1;
        reached = 1'b0;
        for (int c = 0; c < 300 && !reached; c++) begin
            step();
            if (lfo_value == 8'd128) begin
                frequency = 32'hFFFFFFFF;
                reached = 1'b1;
            end
        end
        n_tests++;
        if (!reached) begin
            n_fail++;
            $display("FAIL wrap_lfo_reach: lfo=%0d, required 128 within 300 cycles", lfo_value);
        end
        bad = 0;
        for (int it = 0; it < 3002; it++) begin
            step();
            if (it >= 2) begin
                k = it - 1;
                exp_v = (k <= 80) ? 24'h0 : 24'(k - 80);
                n_tests++;
                if (sample_out_valid !== 1'b1 || sample_out !== exp_v) begin
                    n_fail++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL wrap out %0d: valid=%b out=%h, required 1/%h",
                                 k, sample_out_valid, sample_out, exp_v);
                end
            end
            if (it < 3000) begin
                sample_in = 24'(it + 1);
                sample_in_valid = 1'b1;
            end else begin
                sample_in_valid = 1'b0;
            end
        end
        n_tests++;
        if (lfo_value !== 8'd128) begin
            n_fail++;
            $display("FAIL wrap_lfo_frozen: lfo=%0d, required 128", lfo_value);
        end
        $display("[TB] test_wrap done");
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_lfo_rate();
        test_freq_zero();
        test_fixed_delay();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
